// File: rtl/fifo_flag_window_gen_if.sv
// Bundle of per-channel triggers, window lengths and the flag/done/miss outputs.
// The master side drives the triggers and lengths; the slave side (the generator) returns the flags.
interface fifo_flag_window_gen_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH*CNT_W-1:0] len;
  logic [NUM_CH-1:0]       flag;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH-1:0]       miss;
  logic                    any_flag;

  modport master (output enable, len, input flag, done, miss, any_flag);
  modport slave  (input enable, len, output flag, done, miss, any_flag);
endinterface

// File: rtl/fifo_flag_window_gen.sv
// Per-channel flag window stretcher: flag is combinational (zero latency), done/miss register on the falling edge.
// No backpressure: every trigger is either accepted, reloads the window, or is reported through miss.
module fifo_flag_window_gen #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 8,
  parameter bit RETRIGGER = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  fifo_flag_window_gen_if.slave  bus
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e            state_q [NUM_CH];
  logic [CNT_W-1:0]  rem_q   [NUM_CH];
  logic [CNT_W-1:0]  load_d  [NUM_CH];
  logic [NUM_CH-1:0] active;
  logic [NUM_CH-1:0] done_q;
  logic [NUM_CH-1:0] miss_q;

  // len==0 wraps to all-ones here, which is exactly the 2^CNT_W window minus the trigger cycle.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      load_d[i] = bus.len[i*CNT_W +: CNT_W] - ONE;
      active[i] = (state_q[i] == ACTIVE);
    end
  end

  always_ff @(negedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        rem_q[i]   <= '0;
      end
      done_q <= '0;
      miss_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        done_q[i] <= 1'b0;
        miss_q[i] <= 1'b0;
        case (state_q[i])
          IDLE: begin
            if (bus.enable[i]) begin
              if (load_d[i] == '0) begin
                done_q[i] <= 1'b1;
              end else begin
                rem_q[i]   <= load_d[i];
                state_q[i] <= ACTIVE;
              end
            end
          end
          ACTIVE: begin
            if (bus.enable[i] && RETRIGGER) begin
              rem_q[i] <= load_d[i];
            end else begin
              miss_q[i] <= bus.enable[i];
              if (rem_q[i] == ONE) begin
                state_q[i] <= IDLE;
                rem_q[i]   <= '0;
                done_q[i]  <= 1'b1;
              end else begin
                rem_q[i] <= rem_q[i] - ONE;
              end
            end
          end
          default: begin
            state_q[i] <= IDLE;
            rem_q[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.flag     = {NUM_CH{reset_n}} & (active | bus.enable);
  assign bus.done     = done_q;
  assign bus.miss     = miss_q;
  assign bus.any_flag = |bus.flag;

endmodule
